// File: rtl/fetch_debug_pkg.sv
// fetch_debug_pkg
// Shared definitions for the fetch-stage debug sequencer: word/byte widths,
// the end-of-program marker, UART command bytes and the FSM state encoding.
// Also intended for use by the UART TX reporter.
// Optional feature macro used by the top: FETCH_DEBUG_CYCLE_CNT_EN.
package fetch_debug_pkg;

  localparam int INST_W = 32;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 10;

  localparam logic [INST_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [BYTE_W-1:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [BYTE_W-1:0] CMD_RUN  = 8'h43;  // 'C'
  localparam logic [BYTE_W-1:0] CMD_STEP = 8'h53;  // 'S'

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_CMD = 3'd2,
    ST_RUN      = 3'd3,
    ST_STEP     = 3'd4,
    ST_HALTED   = 3'd5
  } state_t;

endpackage

// File: rtl/fetch_debug_ctrl_word_assembler.sv
// word_assembler
// Collects UART bytes little-endian into 32-bit words. The fourth byte is not
// stored; it is combined straight into the emitted word so the parent can
// register the write on the same edge that samples the final byte.
// Ports:
//   clk, rst        clock, async active-low reset
//   clr             restart at byte 0 and clear the partial word
//   en              accept byte_in this cycle
//   byte_in         incoming byte
//   word_valid      high in the cycle the fourth byte is accepted
//   word            assembled word (valid with word_valid)
module word_assembler
  import fetch_debug_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid,
  output logic [INST_W-1:0] word
);

  logic [1:0]                 idx;
  logic [INST_W-BYTE_W-1:0]   shift_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= 2'd0;
      shift_q <= '0;
    end else if (clr) begin
      idx     <= 2'd0;
      shift_q <= '0;
    end else if (en) begin
      case (idx)
        2'd0:    shift_q[7:0]   <= byte_in;
        2'd1:    shift_q[15:8]  <= byte_in;
        2'd2:    shift_q[23:16] <= byte_in;
        default: ;
      endcase
      idx <= idx + 2'd1;
    end
  end

  assign word_valid = en && (idx == 2'd3);
  assign word       = {byte_in, shift_q};

endmodule

// File: rtl/fetch_debug_ctrl.sv
// fetch_debug_ctrl
// Debug sequencer for the instruction-fetch stage: loads a program from the
// UART byte stream into instruction memory, then gates PC advance in
// continuous-run or single-step mode until the HALT word is fetched.
// Optional macro FETCH_DEBUG_CYCLE_CNT_EN adds run_cycles (cycles with PC
// enabled since the last load).
// Ports:
//   clk, rst          clock, async active-low reset
//   rx_data/rx_valid  UART byte and one-cycle strobe
//   if_instruction    instruction presented by the fetch stage
//   wr_instruction    one-cycle memory write strobe
//   data_instruction  word written (held after the strobe)
//   stop_pc           1 = freeze PC
//   inst_count        words written since the last load (saturating)
//   busy              high in LOAD/RUN/STEP
//   done              level, program reached HALT in run/step
//   run_cycles        (macro only) cycles with stop_pc=0
//
// state       | meaning
// ------------+----------------------------------------------
// ST_IDLE     | after reset, waiting for 'L'
// ST_LOAD     | assembling bytes into words, writing memory
// ST_WAIT_CMD | program loaded, waiting for 'C', 'S' or 'L'
// ST_RUN      | PC free-running until HALT is fetched
// ST_STEP     | PC enabled for a single cycle
// ST_HALTED   | HALT fetched, done high, waiting for 'L'
module fetch_debug_ctrl
  import fetch_debug_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic [INST_W-1:0] if_instruction,
  output logic              wr_instruction,
  output logic [INST_W-1:0] data_instruction,
  output logic              stop_pc,
  output logic [CNT_W-1:0]  inst_count,
  output logic              busy,
  output logic              done
`ifdef FETCH_DEBUG_CYCLE_CNT_EN
  ,
  output logic [31:0]       run_cycles
`endif
);

  state_t state, state_nx;

  logic              load_entry;
  logic              asm_en;
  logic              word_valid;
  logic [INST_W-1:0] word;
  logic              wr_nx;
  logic [INST_W-1:0] data_nx;
  logic [CNT_W-1:0]  cnt_nx;
  logic              done_nx;

  assign asm_en = (state == ST_LOAD) && rx_valid;

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (load_entry),
    .en         (asm_en),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load_entry = 1'b0;
    wr_nx      = 1'b0;
    data_nx    = data_instruction;
    cnt_nx     = inst_count;
    done_nx    = done;
    case (state)
      ST_IDLE: begin
        if (rx_valid && rx_data == CMD_LOAD) load_entry = 1'b1;
      end
      ST_LOAD: begin
        if (word_valid) begin
          wr_nx   = 1'b1;
          data_nx = word;
          if (inst_count != CNT_MAX) cnt_nx = inst_count + CNT_W'(1);
          if (word == HALT_WORD) state_nx = ST_WAIT_CMD;
        end
      end
      ST_WAIT_CMD: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_LOAD: load_entry = 1'b1;
            CMD_RUN:  state_nx   = ST_RUN;
            CMD_STEP: state_nx   = ST_STEP;
            default:  ;
          endcase
        end
      end
      ST_RUN: begin
        if (if_instruction == HALT_WORD) begin
          state_nx = ST_HALTED;
          done_nx  = 1'b1;
        end
      end
      ST_STEP: begin
        if (if_instruction == HALT_WORD) begin
          state_nx = ST_HALTED;
          done_nx  = 1'b1;
        end else begin
          state_nx = ST_WAIT_CMD;
        end
      end
      ST_HALTED: begin
        if (rx_valid && rx_data == CMD_LOAD) load_entry = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (load_entry) begin
      state_nx = ST_LOAD;
      cnt_nx   = '0;
      done_nx  = 1'b0;
    end
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_instruction   <= 1'b0;
      data_instruction <= '0;
      stop_pc          <= 1'b1;
      inst_count       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      wr_instruction   <= wr_nx;
      data_instruction <= data_nx;
      stop_pc          <= !(state_nx == ST_RUN || state_nx == ST_STEP);
      inst_count       <= cnt_nx;
      busy             <= (state_nx == ST_LOAD) || (state_nx == ST_RUN) ||
                          (state_nx == ST_STEP);
      done             <= done_nx;
    end
  end

`ifdef FETCH_DEBUG_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            run_cycles <= '0;
    else if (load_entry) run_cycles <= '0;
    else if (!stop_pc)   run_cycles <= run_cycles + 32'd1;
  end
`endif

endmodule
